// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, scan-state type and anode helper for the seven-segment scan.
package disp_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} scan_state_t;

    function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction
endpackage

// File: rtl/pixel_clk.sv
// pixel_clk: divides clk by DIV and emits a one-cycle tick on the last count.
module pixel_clk #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("pixel_clk: DIV must be at least 2");
    end

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    // Decoded from the counter register, so it is low in reset and never spans two cycles.
    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/pixel_controller.sv
// pixel_controller: steps an 8-digit scan on each refresh tick and drives the digit select
// and active-low anodes from registers loaded with the next state.
module pixel_controller
    import disp_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 480
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_DIGITS-1:0] dig_en,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [2:0]            seg_sel,
    output logic                  tick
);
    localparam int DIV = CLK_HZ / REFRESH_HZ;

    scan_state_t           state_q, state_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [2:0]            seg_sel_q;

    pixel_clk #(.DIV(DIV)) u_pixel_clk (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Outputs come from the next state so select and anode move together on the stepping edge.
    always_comb begin
        state_d = tick ? scan_state_t'(state_q + 3'd1) : state_q;
        anode_d = dig_en[state_d] ? anode_onehot_n(state_d) : ANODE_OFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S0;
            seg_sel_q <= 3'd0;
            anode_q   <= ANODE_OFF;
        end else begin
            state_q   <= state_d;
            seg_sel_q <= state_d;
            anode_q   <= anode_d;
        end
    end

    assign anode   = anode_q;
    assign seg_sel = seg_sel_q;
endmodule
